// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong 8x8 transpose store between the row-pass and
// column-pass 1-D DCT stages. Rows are written into one bank while the other
// bank is read out column by column. Coefficients are copied bit-exact.
module dct_transpose_buffer #(
    parameter int W = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] y0,
    input  logic signed [W-1:0] y1,
    input  logic signed [W-1:0] y2,
    input  logic signed [W-1:0] y3,
    input  logic signed [W-1:0] y4,
    input  logic signed [W-1:0] y5,
    input  logic signed [W-1:0] y6,
    input  logic signed [W-1:0] y7,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] col0,
    output logic signed [W-1:0] col1,
    output logic signed [W-1:0] col2,
    output logic signed [W-1:0] col3,
    output logic signed [W-1:0] col4,
    output logic signed [W-1:0] col5,
    output logic signed [W-1:0] col6,
    output logic signed [W-1:0] col7,
    output logic [2:0]          out_col,
    output logic                out_last
);

    logic [W-1:0] bank_q [2][8][8];
    logic [1:0]   full_q, full_d;
    logic         wb_q, wb_d;
    logic         rb_q, rb_d;
    logic [2:0]   wr_q, wr_d;
    logic [2:0]   rc_q, rc_d;
    logic [W-1:0] row_in  [8];
    logic [W-1:0] col_out [8];
    logic         wr_fire;
    logic         rd_fire;

    assign row_in[0] = y0;
    assign row_in[1] = y1;
    assign row_in[2] = y2;
    assign row_in[3] = y3;
    assign row_in[4] = y4;
    assign row_in[5] = y5;
    assign row_in[6] = y6;
    assign row_in[7] = y7;

    // Outputs are forced quiet while rst is high so stale flags never leak out.
    assign in_ready  = !full_q[wb_q] && !rst;
    assign out_valid = full_q[rb_q] && !rst;
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign out_col   = rst ? 3'd0 : rc_q;
    assign out_last  = out_valid && (rc_q == 3'd7);

    // Column mux: element i of the presented column comes from row i of the read bank.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            col_out[i] = rst ? '0 : bank_q[rb_q][i][rc_q];
        end
    end

    assign col0 = col_out[0];
    assign col1 = col_out[1];
    assign col2 = col_out[2];
    assign col3 = col_out[3];
    assign col4 = col_out[4];
    assign col5 = col_out[5];
    assign col6 = col_out[6];
    assign col7 = col_out[7];

    // Next-state for pointers, counters and full flags; a fill and a drain in the
    // same cycle always touch different banks, so both flag updates apply.
    always_comb begin
        wb_d   = wb_q;
        wr_d   = wr_q;
        rb_d   = rb_q;
        rc_d   = rc_q;
        full_d = full_q;
        if (wr_fire) begin
            wr_d = wr_q + 3'd1;
            if (wr_q == 3'd7) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end
        if (rd_fire) begin
            rc_d = rc_q + 3'd1;
            if (rc_q == 3'd7) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end
        end
    end

    // Control register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wr_q   <= 3'd0;
            rc_q   <= 3'd0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wr_q   <= wr_d;
            rc_q   <= rc_d;
        end
    end

    // Bank storage: cleared on reset, one full row written per accepted cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        bank_q[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_fire) begin
            for (int j = 0; j < 8; j++) begin
                bank_q[wb_q][wr_q][j] <= row_in[j];
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: a block-FIFO model predicts every output each
// cycle, and directed sequences add literal checks on latency and data.
module tb_dct_transpose_buffer;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] yv [8];
    logic         in_ready;
    logic         out_valid;
    logic         out_last;
    logic [2:0]   out_col;
    logic signed [W-1:0] c0, c1, c2, c3, c4, c5, c6, c7;
    logic [W-1:0] colv [8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dct_transpose_buffer #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0(yv[0]), .y1(yv[1]), .y2(yv[2]), .y3(yv[3]),
        .y4(yv[4]), .y5(yv[5]), .y6(yv[6]), .y7(yv[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .col0(c0), .col1(c1), .col2(c2), .col3(c3),
        .col4(c4), .col5(c5), .col6(c6), .col7(c7),
        .out_col(out_col), .out_last(out_last)
    );

    assign colv[0] = c0;
    assign colv[1] = c1;
    assign colv[2] = c2;
    assign colv[3] = c3;
    assign colv[4] = c4;
    assign colv[5] = c5;
    assign colv[6] = c6;
    assign colv[7] = c7;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: FIFO of up to two complete blocks plus one block being assembled.
    logic [W-1:0] mdata [2][8][8];
    logic [W-1:0] mpart [8][8];
    int           mcount = 0;
    bit           mhead = 1'b0;
    logic [2:0]   mcol = 3'd0;
    logic [2:0]   mrow = 3'd0;
    bit           post_rst = 1'b0;
    bit           started = 1'b0;

    // Model update on the clock edge from the inputs the bench is driving.
    always @(posedge clk) begin
        bit acc;
        bit hs;
        bit tail;
        started = 1'b1;
        if (rst) begin
            mcount   = 0;
            mhead    = 1'b0;
            mcol     = 3'd0;
            mrow     = 3'd0;
            post_rst = 1'b1;
        end else begin
            post_rst = 1'b0;
            acc = in_valid && (mcount < 2);
            hs  = (mcount > 0) && out_ready;
            if (hs) begin
                if (mcol == 3'd7) begin
                    mcol   = 3'd0;
                    mhead  = ~mhead;
                    mcount = mcount - 1;
                end else begin
                    mcol = mcol + 3'd1;
                end
            end
            if (acc) begin
                for (int j = 0; j < 8; j++) mpart[mrow][j] = yv[j];
                if (mrow == 3'd7) begin
                    tail = mhead ^ (mcount == 1);
                    for (int r = 0; r < 8; r++)
                        for (int j = 0; j < 8; j++)
                            mdata[tail][r][j] = mpart[r][j];
                    mcount = mcount + 1;
                    mrow   = 3'd0;
                end else begin
                    mrow = mrow + 3'd1;
                end
            end
        end
    end

    // Compare process: mid-cycle, DUT outputs against the model.
    always @(negedge clk) begin
        bit er;
        bit ev;
        if (started) begin
            er = !rst && (mcount < 2);
            ev = !rst && (mcount > 0);
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                for (int i = 0; i < 8; i++)
                    chk("col_data", 32'(colv[i]), 32'(mdata[mhead][i][mcol]));
                chk("out_col", 32'(out_col), 32'(mcol));
                chk("out_last", 32'(out_last), 32'(mcol == 3'd7));
            end else begin
                chk("out_last_idle", 32'(out_last), 32'd0);
            end
            if (rst || post_rst) begin
                for (int i = 0; i < 8; i++) chk("col_reset", 32'(colv[i]), 32'd0);
                chk("out_col_reset", 32'(out_col), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int vcnt;
    int drops;
    int acc_rows;

    initial begin
        for (int j = 0; j < 8; j++) yv[j] = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single block: yj = 10r + j, drain with out_ready held high.
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int j = 0; j < 8; j++) yv[j] = W'(10 * r + j);
            step();
        end
        in_valid = 1'b0;
        chk("single_latency", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++) chk("single_col", 32'(colv[i]), 32'(10 * i + c));
            chk("single_last", 32'(out_last), 32'(c == 7));
            step();
        end
        chk("single_empty", 32'(out_valid), 32'd0);

        // Streaming: three back-to-back blocks.
        vcnt  = 0;
        drops = 0;
        for (int k = 0; k < 32; k++) begin
            in_valid  = (k < 24);
            out_ready = 1'b1;
            for (int j = 0; j < 8; j++) yv[j] = W'(1000 * (k / 8) + 10 * (k % 8) + j);
            if (k >= 8 && out_valid) vcnt++;
            if (k < 24 && !in_ready) drops++;
            step();
        end
        in_valid = 1'b0;
        chk("stream_valid_cycles", 32'(vcnt), 32'd24);
        chk("stream_ready_drops", 32'(drops), 32'd0);

        // Backpressure: out_ready low, in_valid held high.
        out_ready = 1'b0;
        acc_rows  = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            for (int j = 0; j < 8; j++) yv[j] = W'(2000 + 100 * (acc_rows / 8) + 10 * (acc_rows % 8) + j);
            if (in_ready) acc_rows++;
            step();
        end
        chk("bp_rows_accepted", 32'(acc_rows), 32'd16);
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("bp_ready_held", 32'(in_ready), 32'd0);
            step();
        end
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        in_valid = 1'b0;

        // Output stall: out_ready pattern 1,0,0,1 while the second block drains.
        for (int k = 0; k < 40; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        out_ready = 1'b0;

        // Sign and width extremes.
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int j = 0; j < 8; j++) begin
                case ((r + j) % 3)
                    0:       yv[j] = {W{1'b1}};
                    1:       yv[j] = {1'b1, {(W-1){1'b0}}};
                    default: yv[j] = {1'b0, {(W-1){1'b1}}};
                endcase
            end
            step();
        end
        in_valid = 1'b0;
        chk("sign_neg1", 32'(colv[0]), 32'h001F_FFFF);
        chk("sign_min", 32'(colv[1]), 32'h0010_0000);
        chk("sign_max", 32'(colv[2]), 32'h000F_FFFF);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        out_ready = 1'b0;

        // Reset mid-operation: block B partly drained, block A has 5 rows.
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int j = 0; j < 8; j++) yv[j] = W'(3000 + 10 * r + j);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            out_ready = (k < 3);
            for (int j = 0; j < 8; j++) yv[j] = W'(4000 + 10 * k + j);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_col", 32'(colv[0]), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_col", 32'(colv[3]), 32'd0);
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int j = 0; j < 8; j++) yv[j] = W'(5000 + 10 * r + j);
            step();
        end
        in_valid = 1'b0;
        chk("blockc_latency", 32'(out_valid), 32'd1);
        chk("blockc_col0", 32'(colv[1]), 32'd5010);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        out_ready = 1'b0;
        chk("blockc_empty", 32'(out_valid), 32'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dct_transpose_buffer.md
# dct_transpose_buffer

Ping-pong 8x8 transpose memory between the row-pass and column-pass 1-D DCT stages of the 2-D DCT pipeline. It accepts one 8-coefficient row result per cycle and stores a full 8x8 block. It then emits the block column by column, so the column-pass stage receives transposed data. Two banks let one block fill while the previous block drains, which sustains full throughput without bubbles.

## Interface
- W, 21: width of each signed row-pass coefficient, stored and forwarded verbatim.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  row y0..y7 is present this cycle.
- in_ready  out  1  buffer can accept a row this cycle.
- y0..y7  in  W each, signed  row-pass coefficients of the current row; yj is column j.
- out_valid  out  1  col0..col7 hold a valid column.
- out_ready  in  1  downstream consumes the column this cycle.
- col0..col7  out  W each, signed  current column; coli is the element from row i.
- out_col  out  3  index (0..7) of the column being presented.
- out_last  out  1  high with column 7 of a block.

## Operation
**Storage**
- Two banks, B0 and B1. Each bank holds 8x8 words of W bits.
- Each bank has a full flag.

**Write side**
- Registers: write-bank pointer wb and row counter wr (3 bits).
- in_ready = !full[wb] and !rst.
- On in_valid && in_ready:
  - Bank[wb][wr][j] <= yj for j = 0..7.
  - wr increments.
- When wr = 7 is accepted:
  - full[wb] <= 1.
  - wb toggles.
  - wr wraps to 0.
- in_valid while in_ready = 0 is ignored. The upstream stage must hold its data.

**Read side**
- Registers: read-bank pointer rb and column counter rc (3 bits).
- out_valid = full[rb].
- coli = Bank[rb][i][rc]. This is a combinational mux from bank registers.
- out_col = rc.
- out_last = out_valid && rc = 7.
- On out_valid && out_ready:
  - rc increments.
- On the handshake at rc = 7:
  - full[rb] <= 0.
  - rb toggles.
  - rc wraps to 0.
- While out_valid && !out_ready, col0..col7, out_col and out_last stay stable.

**Simultaneous events**
- A set of full on one bank and a clear of full on the other bank in the same cycle are both applied.
- Write into wb and read from rb proceed in the same cycle. They always target different banks whenever both are active.

**Reset (rst = 1 at a clock edge)**
- Both full flags are cleared, and wb = rb = 0, wr = rc = 0.
- All bank words are cleared to 0.
- Output values during and immediately after reset:
  - out_valid = 0, out_last = 0, out_col = 0.
  - col0..col7 = 0.
  - in_ready = 0 while rst is high, and 1 on the first cycle after reset.
- A partially written or partially drained block is discarded. No column of it appears after reset.

**Arithmetic**
- None. Data is copied bit-exact, and sign is preserved.

## Timing
- Latency: last row (wr = 7) accepted at edge N gives out_valid = 1, with column 0 of that block, in cycle N+1.
- Throughput:
  - One row in per cycle and one column out per cycle.
  - With in_valid and out_ready held high, in_ready never drops after the first block.
  - out_valid stays continuously high from cycle 8 onward.
- Backpressure:
  - With out_ready = 0, at most 16 rows (two blocks) are accepted.
  - in_ready falls in the cycle after row 16 is accepted.
  - in_ready rises in the cycle after the draining bank's column 7 handshake.
- Ordering:
  - Blocks leave in arrival order.
  - Columns within a block leave in order 0..7.

## Test plan
- Single block:
  - Stimulus: rows r = 0..7 with yj = 10r + j. Then hold out_ready = 1.
  - Response: out_valid rises 1 cycle after row 7. Column c gives coli = 10i + c for c = 0..7, and out_last = 1 only at c = 7.
- Streaming:
  - Stimulus: 3 blocks back-to-back, with in_valid = out_ready = 1 for 24 cycles.
  - Response: in_ready is always 1, out_valid is high continuously for cycles 8..31, and every column matches its transpose.
- Backpressure:
  - Stimulus: out_ready = 0 and in_valid held high.
  - Response: exactly 16 rows are accepted, and in_ready = 0 from cycle 16.
  - Then: raise out_ready for 8 cycles. in_ready returns the cycle after the out_last handshake.
- Output stall:
  - Stimulus: toggle out_ready 1,0,0,1,... during a drain.
  - Response: col0..col7 and out_col hold stable while stalled, and no column is skipped or duplicated.
- Sign and width:
  - Stimulus: rows containing -1 (all ones), -2^(W-1) and 2^(W-1)-1.
  - Response: the values appear bit-exact in the transposed positions.
- Reset mid-operation:
  - Stimulus: assert rst after 5 rows of block A, with block B partially drained. Then write block C.
  - Response: after reset, outputs are 0 and out_valid = 0. Only block C's columns appear afterwards, with latency 1 after its row 7.
